// File: rtl/code_packer_pkg.sv
// Shared constants, state type and codeword mask helper for the code packer.
//   OUT_W  : output word width
//   CW_W   : maximum codeword width (2-bit code + 32-bit literal)
//   LEN_W  : codeword length field width
//   CNT_W  : running bit counter width
//   ACC_W  : accumulator width (one output word plus two full codewords)
package code_packer_pkg;

    localparam int OUT_W   = 64;
    localparam int CW_W    = 34;
    localparam int LEN_W   = 6;
    localparam int CNT_W   = 32;
    localparam int CHUNK_W = 2 * CW_W;
    localparam int SUM_W   = LEN_W + 1;
    localparam int ACC_W   = OUT_W + CHUNK_W;
    localparam int FILL_W  = 8;

    typedef enum logic {ST_RUN, ST_FLUSH} pack_state_t;

    // Mask keeping the low 'len' bits of a codeword; any len >= CW_W keeps all bits.
    function automatic logic [CW_W-1:0] cw_mask(input logic [LEN_W-1:0] len);
        logic [CW_W:0] ones;
        ones = ({{CW_W{1'b0}}, 1'b1} << len) - {{CW_W{1'b0}}, 1'b1};
        return ones[CW_W-1:0];
    endfunction

endpackage

// File: rtl/code_packer_if.sv
// Codeword-pair input stream and packed-word output stream of the code packer.
//   slave  : packer side (consumes pairs, produces words)
//   master : environment side (produces pairs, consumes words)
interface code_packer_if;
    import code_packer_pkg::*;

    logic                   i_valid;
    logic                   o_ready;
    logic [CW_W-1:0]        i_cw1;
    logic [LEN_W-1:0]       i_len1;
    logic [CW_W-1:0]        i_cw2;
    logic [LEN_W-1:0]       i_len2;
    logic                   i_flush;
    logic                   o_valid;
    logic                   i_ready;
    logic [OUT_W-1:0]       o_data;
    logic                   o_last;
    logic [CNT_W-1:0]       o_bit_count;

    modport slave (
        input  i_valid, i_cw1, i_len1, i_cw2, i_len2, i_flush, i_ready,
        output o_ready, o_valid, o_data, o_last, o_bit_count
    );

    modport master (
        output i_valid, i_cw1, i_len1, i_cw2, i_len2, i_flush, i_ready,
        input  o_ready, o_valid, o_data, o_last, o_bit_count
    );

endinterface

// File: rtl/code_merge.sv
// Combinational merge of two right-aligned codewords into one left-aligned chunk.
//   cw1/len1 : first codeword, occupies the top len1 bits of chunk
//   cw2/len2 : second codeword, immediately follows cw1
//   chunk    : merged bits, MSB-first, zero below len1+len2
//   len_sum  : len1 + len2
module code_merge
    import code_packer_pkg::*;
(
    input  logic [CW_W-1:0]    cw1,
    input  logic [LEN_W-1:0]   len1,
    input  logic [CW_W-1:0]    cw2,
    input  logic [LEN_W-1:0]   len2,
    output logic [CHUNK_W-1:0] chunk,
    output logic [SUM_W-1:0]   len_sum
);

    logic [CW_W-1:0]    m1_s;
    logic [CW_W-1:0]    m2_s;
    logic [CHUNK_W-1:0] ext1_s;
    logic [CHUNK_W-1:0] ext2_s;

    // Mask stray upper bits, left-align each codeword, then butt cw2 against cw1.
    always_comb begin
        m1_s    = cw1 & cw_mask(len1);
        m2_s    = cw2 & cw_mask(len2);
        ext1_s  = {m1_s, {CW_W{1'b0}}} << (SUM_W'(CW_W) - {1'b0, len1});
        ext2_s  = ({m2_s, {CW_W{1'b0}}} << (SUM_W'(CW_W) - {1'b0, len2})) >> len1;
        chunk   = ext1_s | ext2_s;
        len_sum = {1'b0, len1} + {1'b0, len2};
    end

endmodule

// File: rtl/code_packer.sv
// Packs up to two variable-length codewords per cycle MSB-first into fixed
// OUT_W-bit output words; a flush emits the zero-padded tail word tagged o_last.
//   i_clk   : clock
//   i_reset : synchronous reset, active-low
//   bus     : pair input / word output streams (see code_packer_if)
module code_packer
    import code_packer_pkg::*;
(
    input  logic           i_clk,
    input  logic           i_reset,
    code_packer_if.slave   bus
);

    pack_state_t         state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                o_valid_q, o_valid_d;
    logic [OUT_W-1:0]    o_data_q, o_data_d;
    logic                o_last_q, o_last_d;

    logic [CHUNK_W-1:0]  chunk_s;
    logic [SUM_W-1:0]    len_sum_s;
    logic                drain_s;
    logic                ready_s;
    logic                accept_s;
    logic [FILL_W-1:0]   fill_base_s;
    logic [ACC_W-1:0]    acc_base_s;
    logic [ACC_W-1:0]    ins_s;

    code_merge u_merge (
        .cw1     (bus.i_cw1),
        .len1    (bus.i_len1),
        .cw2     (bus.i_cw2),
        .len2    (bus.i_len2),
        .chunk   (chunk_s),
        .len_sum (len_sum_s)
    );

    // Next-state logic: drain first, then append the accepted pair behind what is left.
    always_comb begin
        drain_s     = o_valid_q & bus.i_ready;
        fill_base_s = drain_s ? (fill_q - FILL_W'(OUT_W)) : fill_q;
        acc_base_s  = drain_s ? (acc_q << OUT_W) : acc_q;
        ready_s     = (state_q == ST_RUN) && (fill_base_s < FILL_W'(OUT_W));
        accept_s    = bus.i_valid & ready_s;
        ins_s       = {chunk_s, {OUT_W{1'b0}}} >> fill_base_s;

        state_d = state_q;
        acc_d   = acc_base_s;
        fill_d  = fill_base_s;
        cnt_d   = cnt_q;

        case (state_q)
            ST_RUN: begin
                if (accept_s) begin
                    acc_d  = acc_base_s | ins_s;
                    fill_d = fill_base_s + FILL_W'(len_sum_s);
                    cnt_d  = cnt_q + CNT_W'(len_sum_s);
                end else begin
                    acc_d  = acc_base_s;
                    fill_d = fill_base_s;
                end
                if (bus.i_flush) begin
                    state_d = ST_FLUSH;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                // The tail word holds fewer than OUT_W bits; draining it empties the packer.
                if (drain_s && o_last_q) begin
                    acc_d   = {ACC_W{1'b0}};
                    fill_d  = {FILL_W{1'b0}};
                    state_d = ST_RUN;
                end else begin
                    acc_d   = acc_base_s;
                    fill_d  = fill_base_s;
                    state_d = ST_FLUSH;
                end
            end
            default: begin
                acc_d   = {ACC_W{1'b0}};
                fill_d  = {FILL_W{1'b0}};
                state_d = ST_RUN;
            end
        endcase

        // Outputs are registered from next state, so they hold while i_ready is low.
        o_data_d  = acc_d[ACC_W-1 -: OUT_W];
        o_valid_d = (state_d == ST_FLUSH) || (fill_d >= FILL_W'(OUT_W));
        o_last_d  = (state_d == ST_FLUSH) && (fill_d < FILL_W'(OUT_W));
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q   <= ST_RUN;
            acc_q     <= {ACC_W{1'b0}};
            fill_q    <= {FILL_W{1'b0}};
            cnt_q     <= {CNT_W{1'b0}};
            o_valid_q <= 1'b0;
            o_data_q  <= {OUT_W{1'b0}};
            o_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            fill_q    <= fill_d;
            cnt_q     <= cnt_d;
            o_valid_q <= o_valid_d;
            o_data_q  <= o_data_d;
            o_last_q  <= o_last_d;
        end
    end

    assign bus.o_ready     = ready_s;
    assign bus.o_valid     = o_valid_q;
    assign bus.o_data      = o_data_q;
    assign bus.o_last      = o_last_q;
    assign bus.o_bit_count = cnt_q;

endmodule
